// File: rtl/full_adder.sv
// One-bit full adder cell. Purely combinational; the serial adder controller
// instantiates one copy and steps it across its operands.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder walks WIDTH-bit operands LSB first, one bit
// per clock, with a start/ready handshake in and a one-cycle done pulse out.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             fa_s, fa_c;

   full_adder u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_c)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Result bits enter at the MSB so the LSB lands in sum[0] after WIDTH shifts.
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {fa_s, sum_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cout_d  = fa_c;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   // Handshake outputs decode registered state only; start has no combinational path out.
   assign ready = (state_q == S_IDLE);
   assign busy  = ~ready;
   assign done  = (state_q == S_DONE);
   assign sum   = sum_q;
   assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=4 with hand-computed results.
module tb_serial_adder_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst, start, cin;
   logic [W-1:0] a, b;
   logic         ready, busy, done, cout;
   logic [W-1:0] sum;

   int errors = 0;
   int checks = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One add from IDLE: checks accept response, latency, result and the single-cycle done.
   task automatic do_add(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic [W-1:0] es, input logic ec);
      int lat;
      a = ia; b = ib; cin = ic; start = 1'b1;
      step();
      start = 1'b0; a = '0; b = '0; cin = 1'b0;
      chk({tag, "_ready_low"}, 32'(ready), 32'd0);
      chk({tag, "_sum_cleared"}, 32'(sum), 32'd0);
      lat = 0;
      while (!done && lat < 12) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(W));
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
      step();
      chk({tag, "_done_width"}, 32'(done), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready), 32'd1);
      chk({tag, "_sum_held"}, 32'(sum), 32'(es));
   endtask

   logic [W-1:0] va [3] = '{4'd1, 4'd9, 4'd12};
   logic [W-1:0] vb [3] = '{4'd2, 4'd8, 4'd4};
   logic         vc [3] = '{1'b0, 1'b1, 1'b0};
   logic [W-1:0] xs [3] = '{4'd3, 4'd2, 4'd0};
   logic         xc [3] = '{1'b0, 1'b1, 1'b1};

   initial begin
      int ndone, idx, last_e;
      logic [W-1:0] cap_sum;
      logic         cap_cout;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      step(); step();
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      rst = 1'b0;
      step();

      do_add("add_5_3", 4'd5, 4'd3, 1'b0, 4'd8, 1'b0);
      do_add("add_15_1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
      do_add("add_15_15_c", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1);

      // start during RUN must be ignored
      a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      chk("ign_busy", 32'(busy), 32'd1);
      ndone = 0; cap_sum = '1; cap_cout = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 1) begin a = 4'd7; b = 4'd7; start = 1'b1; end
         if (i == 2) start = 1'b0;
         step();
         if (done) begin ndone++; cap_sum = sum; cap_cout = cout; end
      end
      chk("ign_ndone", 32'(ndone), 32'd1);
      chk("ign_sum", 32'(cap_sum), 32'd4);
      chk("ign_cout", 32'(cap_cout), 32'd0);

      // reset two cycles into RUN aborts the add
      a = 4'd9; b = 4'd9; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done) ndone++;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      do_add("post_abort", 4'd6, 4'd7, 1'b1, 4'd14, 1'b0);

      // start held high: back-to-back adds spaced WIDTH+2 cycles
      ndone = 0; idx = 0; last_e = 0;
      for (int e = 0; e < 24; e++) begin
         if (ready) begin
            if (idx < 3) begin
               a = va[idx]; b = vb[idx]; cin = vc[idx]; start = 1'b1;
               idx++;
            end else begin
               start = 1'b0;
            end
         end
         step();
         if (done) begin
            if (ndone < 3) begin
               chk($sformatf("b2b_sum%0d", ndone), 32'(sum), 32'(xs[ndone]));
               chk($sformatf("b2b_cout%0d", ndone), 32'(cout), 32'(xc[ndone]));
            end
            if (ndone > 0) chk($sformatf("b2b_gap%0d", ndone), 32'(e - last_e), 32'(W + 2));
            last_e = e;
            ndone++;
         end
      end
      chk("b2b_ndone", 32'(ndone), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
